// File: rtl/sar_search_4b.sv
// sar_search_4b -- successive-approximation search engine.
// Presents a trial value on guess to an external magnitude comparator
// (comparator computes target A vs. guess B). It narrows a [lo,hi] window
// from the comparator's one-hot flags until equality is reported. It also
// stops with error when the flags are not one-hot, or when they contradict
// the remaining window.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   start   in   1      launch a search; sampled only in IDLE
//   cmp_gt  in   1      comparator: target > guess
//   cmp_eq  in   1      comparator: target == guess
//   cmp_lt  in   1      comparator: target < guess
//   guess   out  WIDTH  registered trial value for the comparator B input
//   busy    out  1      high while probing
//   done    out  1      one-cycle completion pulse (success or error)
//   result  out  WIDTH  found value (last guess on error), held until next start
//   error   out  1      inconsistent feedback, held until next start
module sar_search_4b #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    FINISH
  } state_t;

  localparam logic [WIDTH:0]   ONE_W  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] FIRST  = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo, hi;
  logic [WIDTH-1:0] lo_nxt, hi_nxt, guess_nxt, result_nxt;
  logic             error_nxt;
  logic             fail;

  // Midpoints of the narrowed windows, one bit wider so lo+hi cannot wrap.
  // sum_lt is only used when guess > lo, so guess-1 never underflows there.
  logic [WIDTH:0] sum_gt, sum_lt;
  assign sum_gt = {1'b0, guess} + ONE_W + {1'b0, hi};
  assign sum_lt = {1'b0, lo} + {1'b0, guess} - ONE_W;

  assign busy = (state == PROBE);
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      state  <= state_nxt;
      lo     <= lo_nxt;
      hi     <= hi_nxt;
      guess  <= guess_nxt;
      result <= result_nxt;
      error  <= error_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lo_nxt     = lo;
    hi_nxt     = hi;
    guess_nxt  = guess;
    result_nxt = result;
    error_nxt  = error;
    fail       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          lo_nxt    = '0;
          hi_nxt    = '1;
          guess_nxt = FIRST;
          error_nxt = 1'b0;
          state_nxt = PROBE;
        end
      end

      PROBE: begin
        case ({cmp_gt, cmp_eq, cmp_lt})
          3'b010: begin
            result_nxt = guess;
            state_nxt  = FINISH;
          end
          3'b100: begin
            if (guess == hi) begin
              fail = 1'b1;
            end else begin
              lo_nxt    = guess + ONE;
              guess_nxt = sum_gt[WIDTH:1];
            end
          end
          3'b001: begin
            if (guess == lo) begin
              fail = 1'b1;
            end else begin
              hi_nxt    = guess - ONE;
              guess_nxt = sum_lt[WIDTH:1];
            end
          end
          default: fail = 1'b1;
        endcase

        if (fail) begin
          error_nxt  = 1'b1;
          result_nxt = guess;
          state_nxt  = FINISH;
        end
      end

      FINISH: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

endmodule
